seg_value_fmt: RTL and testbench

- Converts an unsigned binary value (a price, balance or change amount from the vending FSM) into six packed BCD digits for the 6-digit seg display driver.
- Also generates the per-digit enable mask and the active-low decimal-point vector for that driver.
- Uses an iterative double-dabble converter (one bit per clock) with a start/busy/done handshake.
- Outputs hold their last result between conversions, so the display never flickers.

---
 rtl/seg_value_fmt_if.sv | 25 ++
 rtl/seg_value_fmt.sv | 129 ++++++++++++
 tb/tb_seg_value_fmt.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg_value_fmt_if.sv
// Handshake and result bus between the value source and the 6-digit display formatter.
// The source drives start/operands; the formatter returns BCD digits, mask and decimal points.
interface seg_value_fmt_if #(
    parameter int BIN_W = 20
);
    logic             vld_in;
    logic [BIN_W-1:0] bin_in;
    logic [1:0]       frac_digits;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [23:0]      din;
    logic [5:0]       din_mask;
    logic [5:0]       point_n;

    modport master (
        output vld_in, bin_in, frac_digits,
        input  busy, done, ovf, din, din_mask, point_n
    );

    modport slave (
        input  vld_in, bin_in, frac_digits,
        output busy, done, ovf, din, din_mask, point_n
    );
endinterface

// File: rtl/seg_value_fmt.sv
// Binary-to-6-digit BCD formatter (double dabble, one bit per clock) with digit mask and decimal point.
// Latency BIN_W+2 edges from vld_in to done; vld_in while busy is dropped. Macro SEG_FMT_LZB_EN enables leading-zero blanking.
module seg_value_fmt #(
    parameter int BIN_W   = 20,
    parameter int MAX_VAL = 999999
) (
    input  logic          clk,
    input  logic          rst,
    seg_value_fmt_if.slave bus
);
    localparam int          CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [31:0] MAX_U = 32'(MAX_VAL);
    localparam logic [BIN_W-1:0] MAX_B = MAX_U[BIN_W-1:0];

    typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

    state_t           state;
    logic [BIN_W-1:0] sh;
    logic [23:0]      bcd;
    logic [23:0]      bcd_adj;
    logic [1:0]       frac;
    logic             sat;
    logic [CW-1:0]    cnt;
    logic             fmt_ph;
    logic [5:0]       mask_stg;
    logic [5:0]       point_stg;
    logic [5:0]       mask_nxt;
    logic [5:0]       point_nxt;

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 6; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef SEG_FMT_LZB_EN
    // Walk from the top digit down so nz marks "this digit or any higher one is nonzero".
    always_comb begin
        logic nz;
        nz       = 1'b0;
        mask_nxt = 6'b000000;
        for (int k = 5; k >= 0; k--) begin
            nz          = nz | (|bcd[4*k +: 4]);
            mask_nxt[k] = nz | (3'(k) <= {1'b0, frac});
        end
    end
`else
    always_comb begin
        mask_nxt = 6'b111111;
    end
`endif

    always_comb begin
        point_nxt = 6'b111111;
        if (frac != 2'd0) begin
            point_nxt[frac] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sh           <= '0;
            bcd          <= '0;
            frac         <= '0;
            sat          <= 1'b0;
            cnt          <= '0;
            fmt_ph       <= 1'b0;
            mask_stg     <= 6'b000001;
            point_stg    <= 6'b111111;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.ovf      <= 1'b0;
            bus.din      <= 24'h000000;
            bus.din_mask <= 6'b000001;
            bus.point_n  <= 6'b111111;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.vld_in) begin
                        if (32'(bus.bin_in) > MAX_U) begin
                            sh  <= MAX_B;
                            sat <= 1'b1;
                        end else begin
                            sh  <= bus.bin_in;
                            sat <= 1'b0;
                        end
                        bcd      <= '0;
                        frac     <= bus.frac_digits;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[22:0], sh[BIN_W-1]};
                    sh  <= sh << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(BIN_W - 1)) begin
                        fmt_ph <= 1'b0;
                        state  <= FMT;
                    end
                end
                FMT: begin
                    // Stage mask/point first, then publish everything together with done.
                    if (!fmt_ph) begin
                        mask_stg  <= mask_nxt;
                        point_stg <= point_nxt;
                        fmt_ph    <= 1'b1;
                    end else begin
                        bus.din      <= bcd;
                        bus.din_mask <= mask_stg;
                        bus.point_n  <= point_stg;
                        bus.ovf      <= sat;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        fmt_ph       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_value_fmt.sv
// Scoreboard bench for seg_value_fmt: directed conversions, done-cycle restart, busy drop and reset abort.
module tb_seg_value_fmt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [23:0] din;
        logic [5:0]  mask;
        logic [5:0]  pn;
        logic        ovf;
        int          issue_edge;
    } exp_t;

    exp_t q[$];

    seg_value_fmt_if #(.BIN_W(20)) bus ();

    seg_value_fmt #(.BIN_W(20), .MAX_VAL(999999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at edge %0d", edge_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("din", 32'(bus.din), 32'(e.din));
                chk("din_mask", 32'(bus.din_mask), 32'(e.mask));
                chk("point_n", 32'(bus.point_n), 32'(e.pn));
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                chk("latency", 32'(edge_cnt - e.issue_edge), 32'd22);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [19:0] v, input logic [1:0] f, input bit push,
                         input logic [23:0] d, input logic [5:0] m_lzb,
                         input logic [5:0] pn, input logic o);
        exp_t e;
        bus.vld_in      = 1'b1;
        bus.bin_in      = v;
        bus.frac_digits = f;
        @(posedge clk);
        @(negedge clk);
        bus.vld_in = 1'b0;
        if (push) begin
            e.din = d;
`ifdef SEG_FMT_LZB_EN
            e.mask = m_lzb;
`else
            e.mask = 6'b111111;
`endif
            e.pn         = pn;
            e.ovf        = o;
            e.issue_edge = edge_cnt;
            q.push_back(e);
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_din"}, 32'(bus.din), 32'h0);
        chk({tag, "_mask"}, 32'(bus.din_mask), 32'b000001);
        chk({tag, "_point_n"}, 32'(bus.point_n), 32'b111111);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    initial begin
        bus.vld_in      = 1'b0;
        bus.bin_in      = '0;
        bus.frac_digits = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_state("reset");

        issue(20'd25, 2'd1, 1'b1, 24'h000025, 6'b000011, 6'b111101, 1'b0);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        wait_empty();
        chk("busy_after_done", 32'(bus.busy), 32'd0);

        issue(20'd5, 2'd2, 1'b1, 24'h000005, 6'b000111, 6'b111011, 1'b0);
        wait_empty();

        issue(20'd1048575, 2'd0, 1'b1, 24'h999999, 6'b111111, 6'b111111, 1'b1);
        wait_empty();
        chk("ovf_hold", 32'(bus.ovf), 32'd1);

        // Abort a conversion around iteration 10; no done may follow.
        issue(20'd4321, 2'd1, 1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("abort");
        repeat (30) @(negedge clk);

        issue(20'd0, 2'd0, 1'b1, 24'h000000, 6'b000001, 6'b111111, 1'b0);
        wait_empty();

        // Second start 5 cycles after the first must be dropped.
        issue(20'd7, 2'd0, 1'b1, 24'h000007, 6'b000001, 6'b111111, 1'b0);
        repeat (4) @(negedge clk);
        issue(20'd8, 2'd0, 1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
        for (int i = 0; i < 100 && bus.done !== 1'b1; i++) @(negedge clk);
        chk("done_seen", 32'(bus.done), 32'd1);
        issue(20'd8, 2'd0, 1'b1, 24'h000008, 6'b000001, 6'b111111, 1'b0);
        wait_empty();

        issue(20'd123456, 2'd3, 1'b1, 24'h123456, 6'b111111, 6'b110111, 1'b0);
        wait_empty();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
